// File: rtl/stm_frame_builder_pkg.sv
// Shared STM-N framing constants, overhead byte values and types.
package stm_frame_builder_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int STM1_ROW_LEN = 270;
  localparam int STM_ROWS     = 9;
  localparam int VC4_LEN      = 261;
  localparam int C4_LEN       = 260;
  localparam int OH_COLS      = 9;
  localparam int MAX_PTR      = 782;

  localparam byte_t A1_BYTE    = 8'hF6;
  localparam byte_t A2_BYTE    = 8'h28;
  localparam byte_t J0_BYTE    = 8'h01;
  localparam byte_t Y_BYTE     = 8'h9B;
  localparam byte_t ONES_BYTE  = 8'hFF;
  localparam byte_t CC_H1_BYTE = 8'h93;
  localparam byte_t CC_H2_BYTE = 8'hFF;

  // H1 = NDF '0110' + SS '10' + pointer bits 9:8
  localparam logic [5:0] H1_PREFIX = 6'b0110_10;

  function automatic bit stm_n_legal(input int n);
    return (n == 1) || (n == 4) || (n == 16);
  endfunction

endpackage

// File: rtl/stm_soh_gen.sv
// Combinational section-overhead / AU-4 pointer byte for one overhead slot.
module stm_soh_gen
  import stm_frame_builder_pkg::*;
(
  input  logic [3:0] row,
  input  logic [3:0] b,
  input  logic [3:0] t,
  input  logic [9:0] ptr,
  output byte_t      soh_byte
);

  logic trib0;

  assign trib0 = (t == 4'd0);

  always_comb begin
    soh_byte = 8'h00;
    case (row)
      4'd0: begin
        case (b)
          4'd0, 4'd1, 4'd2: soh_byte = A1_BYTE;
          4'd3, 4'd4, 4'd5: soh_byte = A2_BYTE;
          4'd6:             soh_byte = trib0 ? J0_BYTE : 8'h00;
          default:          soh_byte = 8'h00;
        endcase
      end
      4'd3: begin
        // Only tributary 0 carries the real pointer; the rest signal concatenation.
        case (b)
          4'd0:       soh_byte = trib0 ? {H1_PREFIX, ptr[9:8]} : CC_H1_BYTE;
          4'd1, 4'd2: soh_byte = Y_BYTE;
          4'd3:       soh_byte = trib0 ? ptr[7:0] : CC_H2_BYTE;
          4'd4, 4'd5: soh_byte = ONES_BYTE;
          default:    soh_byte = 8'h00;
        endcase
      end
      default: soh_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/stm_frame_builder.sv
// Byte-serial STM-N frame builder: row/column sequencing, overhead insertion,
// payload handshake with zero-fill on underrun, pointer validation.
module stm_frame_builder
  import stm_frame_builder_pkg::*;
#(
  parameter int STM_N  = 1,
  parameter int UCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [9:0]        au_ptr,
  input  byte_t             pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  output byte_t             out_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_sor,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt,
  output logic              ptr_err
);

  localparam int ROW_LEN = STM1_ROW_LEN * STM_N;
  localparam int COL_W   = $clog2(ROW_LEN);
  localparam int LOG_N   = $clog2(STM_N);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ROW_LEN - 1);
  localparam logic [COL_W-1:0]  OH_LIMIT  = COL_W'(OH_COLS * STM_N);
  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
  localparam logic [3:0]        ROW_LAST  = 4'(STM_ROWS - 1);
  localparam logic [3:0]        TRIB_MASK = 4'(STM_N - 1);
  localparam logic [9:0]        PTR_LIMIT = 10'(MAX_PTR);
  localparam logic [UCNT_W-1:0] UCNT_MAX  = {UCNT_W{1'b1}};
  localparam logic [UCNT_W-1:0] UCNT_ONE  = UCNT_W'(1);

  if (!stm_n_legal(STM_N)) begin : g_bad_stm_n
    $error("stm_frame_builder: STM_N must be 1, 4 or 16");
  end

  state_e             state_q, state_d;
  logic [3:0]         row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [9:0]         ptr_q, ptr_d;
  logic               ptr_err_q, ptr_err_d;
  logic [UCNT_W-1:0]  ucnt_q, ucnt_d;
  byte_t              out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sof_q, out_sof_d;
  logic               out_sor_q, out_sor_d;
  logic               underrun_q, underrun_d;

  logic               in_oh;
  logic               frame_start;
  logic [3:0]         oh_b;
  logic [3:0]         oh_t;
  byte_t              soh_byte;

  // N is a power of two, so byte index / tributary are a shift and a mask.
  assign oh_b        = 4'(col_q >> LOG_N);
  assign oh_t        = col_q[3:0] & TRIB_MASK;
  assign in_oh       = (col_q < OH_LIMIT);
  assign frame_start = (state_q == ST_RUN) && (row_q == 4'd0) && (col_q == '0);
  assign pl_ready    = (state_q == ST_RUN) && !in_oh;

  stm_soh_gen u_soh_gen (
    .row      (row_q),
    .b        (oh_b),
    .t        (oh_t),
    .ptr      (ptr_q),
    .soh_byte (soh_byte)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    ptr_d       = ptr_q;
    ptr_err_d   = ptr_err_q;
    ucnt_d      = ucnt_q;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_sor_d   = 1'b0;
    underrun_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        row_d = '0;
        col_d = '0;
        if (en) state_d = ST_RUN;
      end

      ST_RUN: begin
        out_valid_d = 1'b1;
        out_sof_d   = frame_start;
        out_sor_d   = (col_q == '0);

        if (frame_start) begin
          if (au_ptr <= PTR_LIMIT) begin
            ptr_d     = au_ptr;
            ptr_err_d = 1'b0;
          end else begin
            ptr_err_d = 1'b1;
          end
        end

        if (in_oh) begin
          out_data_d = soh_byte;
        end else if (pl_valid) begin
          out_data_d = pl_data;
        end else begin
          underrun_d = 1'b1;
          if (ucnt_q != UCNT_MAX) ucnt_d = ucnt_q + UCNT_ONE;
        end

        // en only matters on the last byte of the frame.
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (!en) state_d = ST_IDLE;
          end else begin
            row_d = row_q + 4'd1;
          end
        end else begin
          col_d = col_q + COL_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      ptr_q       <= '0;
      ptr_err_q   <= 1'b0;
      ucnt_q      <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_sor_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ptr_q       <= ptr_d;
      ptr_err_q   <= ptr_err_d;
      ucnt_q      <= ucnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_sor_q   <= out_sor_d;
      underrun_q  <= underrun_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_sof      = out_sof_q;
  assign out_sor      = out_sor_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;
  assign ptr_err      = ptr_err_q;

endmodule

// File: doc/stm_frame_builder.md
# stm_frame_builder

Builds a byte-serial STM-N frame (N = 1, 4 or 16) of 9 rows × 270·N columns. It generates the byte-interleaved section overhead and AU-4 pointer, and takes VC-4 payload bytes from an upstream valid/ready source. It sits after the VC-4 assembly stage and generalises the fixed STM-1 framing to any N, adding start/stop control, underrun handling and pointer validation.

## Interface
- STM_N, 1, STM order; legal values 1, 4, 16.
- UCNT_W, 16, width of the underrun counter.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; sampled only at frame boundaries.
- au_ptr  in  10  AU-4 pointer value; sampled at frame start.
- pl_data  in  8  payload byte.
- pl_valid  in  1  payload byte available.
- pl_ready  out  1  builder consumes a payload byte this cycle.
- out_data  out  8  frame byte.
- out_valid  out  1  out_data is a frame byte.
- out_sof  out  1  first byte of a frame (row 0, column 0).
- out_sor  out  1  first byte of each row.
- underrun  out  1  this output byte was zero-filled.
- underrun_cnt  out  UCNT_W  saturating underrun count.
- ptr_err  out  1  au_ptr sampled > 782 at the last frame start.

## Operation
- FSM states:
  - IDLE: counters held at 0, pl_ready=0, no output.
  - RUN: one byte per cycle, row r (0..8), column c (0..270·N−1).
- IDLE→RUN when en=1. RUN→IDLE after the last byte (r=8, c=270·N−1) if en=0 at that cycle; otherwise the next frame follows with no gap.
- Column wraps to 0 and the row increments; row 8 wraps to 0 (frame end). frame boundary = (r=0,c=0).
- Overhead columns c < 9·N: STM-1 byte index b = c / N, tributary t = c mod N.
  - Row 0: b 0–2 = 0xF6 (A1), b 3–5 = 0x28 (A2), b 6 = 0x01 (J0) when t=0, otherwise 0x00; b 7–8 = 0x00.
  - Rows 1, 2, 4–8: 0x00.
  - Row 3, t=0:
    - b0 = H1 = {4'b0110, 2'b10, ptr[9:8]}.
    - b3 = H2 = ptr[7:0].
    - b1, b2 = 0x9B (Y).
    - b4, b5 = 0xFF.
    - b6–8 = 0x00 (H3).
  - Row 3, t≠0 (concatenation): b0 = 0x93, b3 = 0xFF, other bytes as for t=0.
- Payload columns c ≥ 9·N: pl_ready=1.
  - pl_valid=1: pl_data is emitted.
  - pl_valid=0: 0x00 is emitted, underrun=1 with that byte, underrun_cnt increments and saturates at all-ones.
- Pointer: au_ptr is sampled at each frame start.
  - Value ≤ 782: becomes ptr and clears ptr_err.
  - Value > 782: ptr keeps its previous value and ptr_err=1 until the next valid sample.
  - ptr resets to 0.
- Arithmetic: column counter is $clog2(270·STM_N) bits. b and t come from a division by a constant power of two; no general divider.

## Timing
- pl_ready is combinational from state and column; a byte is transferred in the cycle pl_valid & pl_ready.
- out_data, out_valid, out_sof, out_sor and underrun are registered: the slot selected in cycle k appears at cycle k+1.
- First out_sof: 2 cycles after the cycle where en=1 is sampled in IDLE.
- Reset values:
  - All outputs 0.
  - underrun_cnt = 0, ptr = 0, ptr_err = 0.
  - State IDLE, counters 0.
- rst mid-frame aborts the frame immediately; outputs are 0 on the next cycle, with no partial completion.
- en toggling mid-frame has no effect until the frame boundary.
- Frame period is 2430·N cycles with no idle gap while en stays high.

## Structure
- Shared package, STM constants:
  - STM1 row length 270, row count 9.
  - VC4 length 261, C4 length 260.
  - Overhead columns 9.
  - Max pointer 782.
- Shared package, byte constants: A1, A2, J0, Y, concatenation H1/H2.
- Shared package, typedefs: byte_t, and a legal-STM_N check.
- Sub-module stm_soh_gen: combinational overhead byte from (row, b, t, ptr). The top level holds the FSM, counters, handshake, output register and statistics.

## Test plan
- STM_N=1, en held, pl_valid=1 with incrementing data: out_sof every 2430 cycles. Row 0 starts F6 F6 F6 28 28 28 01 00 00. Row 3 with au_ptr=522 gives H1=0x6A, H2=0x0A. Payload matches the input order, 2349 bytes/frame.
- STM_N=4: row 0 has 12×F6 then 12×28. Row 3 columns 0–3 = 6A 93 93 93, columns 12–15 = 0A FF FF FF. Period 9720 cycles.
- pl_valid forced low for 5 payload slots: five 0x00 bytes, each with underrun=1; underrun_cnt=5. With UCNT_W=4 and 20 slots, the count saturates at 15.
- en dropped at row 4 mid-frame: the frame completes to r=8, c=270·N−1, then out_valid=0 and pl_ready=0. en re-raised gives out_sof 2 cycles later.
- au_ptr=800 at a frame start: ptr_err=1, and H1/H2 keep the previous pointer 522. Next frame with au_ptr=0: ptr_err=0, H1=0x68, H2=0x00.
- rst asserted at row 2: all outputs 0 next cycle, underrun_cnt=0, and the builder restarts at out_sof after en.
